// File: rtl/airlock_pkg.sv
// Shared airlock definitions: cycle state encoding used by the controller and its benches.
package airlock_pkg;

  typedef enum logic [2:0] {
    PRESSURIZED  = 3'd0,
    EVACUATING   = 3'd1,
    EVACUATED    = 3'd2,
    PRESSURIZING = 3'd3,
    FAULT        = 3'd4
  } airlock_state_t;

  function automatic logic is_pumping(input airlock_state_t s);
    return (s == EVACUATING) || (s == PRESSURIZING);
  endfunction

endpackage

// File: rtl/airlock_settle_cnt.sv
// Pressure-sensor settle filter: accepts a sensor on its SETTLE_CYCLES-th consecutive high sample.
module airlock_settle_cnt #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample,
  output logic accepted
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TOP  = CW'(SETTLE_CYCLES);

  logic [CW-1:0] count_reg;

  // Saturates at SETTLE_CYCLES so a long-held sensor can never wrap back to a low count.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count_reg <= '0;
    end else if (!sample) begin
      count_reg <= '0;
    end else if (count_reg != TOP) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign accepted = sample && (count_reg == LAST);

endmodule

// File: rtl/airlock_cycle_ctrl.sv
// Airlock cycle sequencer (evacuate, hold, repressurize) with door interlocks and latched fault.
// Optional pump timeout is enabled by defining AIRLOCK_TIMEOUT_EN.
module airlock_cycle_ctrl
  import airlock_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic Clock,
  input  logic Reset,
  input  logic begin_Evacuation,
  input  logic begin_Pressurize,
  input  logic InnerClosed,
  input  logic OuterClosed,
  input  logic Evacuated,
  input  logic Pressurized,
  output logic Evacuation,
  output logic Pressurization,
  output logic InnerUnlock,
  output logic OuterUnlock,
  output logic Fault,
  output logic Reject
);

  airlock_state_t state_reg, state_next;
  logic reject_reg, reject_next;
  logic doors_closed;
  logic pumping;
  logic phase_clear;
  logic sensor_sample;
  logic accepted;
  logic timeout;

  assign doors_closed  = InnerClosed & OuterClosed;
  assign pumping       = is_pumping(state_reg);
  // Counters restart on any state change and stay idle outside the pumping states.
  assign phase_clear   = !pumping || (state_next != state_reg);
  assign sensor_sample = (state_reg == EVACUATING)   ? Evacuated :
                         (state_reg == PRESSURIZING) ? Pressurized : 1'b0;

  airlock_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk      (Clock),
    .rst_n    (Reset),
    .clear    (phase_clear),
    .sample   (sensor_sample),
    .accepted (accepted)
  );

`ifdef AIRLOCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_TOP  = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_reg;

  always_ff @(posedge Clock) begin
    if (!Reset || phase_clear) begin
      tmo_reg <= '0;
    end else if (tmo_reg != T_TOP) begin
      tmo_reg <= tmo_reg + 1'b1;
    end
  end

  assign timeout = pumping && (tmo_reg == T_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg  <= PRESSURIZED;
      reject_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      reject_reg <= reject_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    reject_next    = 1'b0;
    Evacuation     = 1'b0;
    Pressurization = 1'b0;
    InnerUnlock    = 1'b0;
    OuterUnlock    = 1'b0;
    Fault          = 1'b0;

    case (state_reg)
      PRESSURIZED: begin
        InnerUnlock = 1'b1;
        if (begin_Evacuation) begin
          if (doors_closed) state_next = EVACUATING;
          else              reject_next = 1'b1;
        end
      end
      EVACUATING: begin
        Evacuation = 1'b1;
        // Door fault outranks acceptance, which outranks timeout.
        if (!doors_closed)  state_next = FAULT;
        else if (accepted)  state_next = EVACUATED;
        else if (timeout)   state_next = FAULT;
      end
      EVACUATED: begin
        OuterUnlock = 1'b1;
        if (begin_Pressurize) begin
          if (doors_closed) state_next = PRESSURIZING;
          else              reject_next = 1'b1;
        end
      end
      PRESSURIZING: begin
        Pressurization = 1'b1;
        if (!doors_closed)  state_next = FAULT;
        else if (accepted)  state_next = PRESSURIZED;
        else if (timeout)   state_next = FAULT;
      end
      FAULT: begin
        Fault = 1'b1;
        if (begin_Pressurize) begin
          if (doors_closed) state_next = PRESSURIZING;
          else              reject_next = 1'b1;
        end
      end
      default: state_next = PRESSURIZED;
    endcase
  end

  assign Reject = reject_reg;

endmodule

// File: doc/airlock_cycle_ctrl.md
# airlock_cycle_ctrl

- Parametrised successor to the single-shot airlock evacuation controller.
- Sequences a complete airlock cycle: evacuate → hold evacuated → repressurize.
- Adds door interlocks, sensor settle filtering, a latched fault state and an optional pump timeout.
- Sits between the operator request inputs and the pump/door-lock actuators.

## Interface
Parameters:
- SETTLE_CYCLES, 4 — consecutive cycles a pressure sensor must read 1 before it is accepted; legal range ≥1.
- TIMEOUT_CYCLES, 64 — maximum cycles in a pumping state before fault; only used with AIRLOCK_TIMEOUT_EN; must be > SETTLE_CYCLES.

Ports (one clock; reset is synchronous and active-low):
- Clock  input  1  system clock, all state changes on rising edge.
- Reset  input  1  synchronous, active-low reset.
- begin_Evacuation  input  1  request to pump chamber down.
- begin_Pressurize  input  1  request to repressurize (also clears fault).
- InnerClosed  input  1  inner door closed sensor.
- OuterClosed  input  1  outer door closed sensor.
- Evacuated  input  1  chamber-at-vacuum sensor.
- Pressurized  input  1  chamber-at-pressure sensor.
- Evacuation  output  1  vacuum pump enable.
- Pressurization  output  1  fill valve enable.
- InnerUnlock  output  1  inner door may open.
- OuterUnlock  output  1  outer door may open.
- Fault  output  1  controller in FAULT.
- Reject  output  1  one-cycle pulse: a request was refused because a door was open.

## Operation
- States: PRESSURIZED, EVACUATING, EVACUATED, PRESSURIZING, FAULT.
- Outputs are Moore, decoded from the state register:
  - InnerUnlock=1 only in PRESSURIZED.
  - Evacuation=1 only in EVACUATING.
  - OuterUnlock=1 only in EVACUATED.
  - Pressurization=1 only in PRESSURIZING.
  - Fault=1 only in FAULT.
- Reject is registered.
- Reset (Reset=0 at an edge):
  - State → PRESSURIZED, counters → 0, Reject → 0.
  - Outputs: InnerUnlock=1, all others 0.
  - Reset mid-cycle aborts pumping immediately.
- Term "doors closed" = InnerClosed & OuterClosed.
- Transitions:
  - PRESSURIZED: begin_Evacuation & doors closed → EVACUATING. begin_Evacuation with a door open → stay, Reject=1 next cycle.
  - EVACUATING: door open → FAULT. Evacuated accepted → EVACUATED.
  - EVACUATED: begin_Pressurize & doors closed → PRESSURIZING. Door open with no request → stay (outer door use is legal). begin_Pressurize with a door open → Reject.
  - PRESSURIZING: door open → FAULT. Pressurized accepted → PRESSURIZED.
  - FAULT: begin_Pressurize & doors closed → PRESSURIZING. Otherwise stay; begin_Evacuation is ignored.
- Requests irrelevant to the current state are ignored without Reject.
- Settle counter, active only in the pumping states:
  - Sensor=1 → increment; sensor=0 → clear.
  - Acceptance when sensor=1 and count==SETTLE_CYCLES-1, i.e. on the SETTLE_CYCLES-th consecutive high sample.
  - Cleared on every state change.
  - Width $clog2(SETTLE_CYCLES+1); never wraps.
- Priority on the same edge: door-open fault > sensor acceptance > timeout.

## Timing
- Request sampled at edge k → new state and outputs valid after edge k; latency 1 cycle.
- With SETTLE_CYCLES=4 and Evacuated rising before edge k, EVACUATED is entered at edge k+3.
- A single-cycle sensor dropout restarts the full settle count.
- Reject is high for exactly the cycle after the refused request; held requests pulse Reject every cycle.

## Configuration
- AIRLOCK_TIMEOUT_EN defined:
  - Timeout counter of width $clog2(TIMEOUT_CYCLES+1) counts cycles spent in EVACUATING/PRESSURIZING; cleared on state change.
  - On the TIMEOUT_CYCLES-th cycle without acceptance → FAULT.
- Not defined: no timeout counter; pumping states last until acceptance or door fault.

## Structure
- Shared package airlock_pkg:
  - State enum typedef airlock_state_t with fixed 3-bit encodings: PRESSURIZED=0, EVACUATING=1, EVACUATED=2, PRESSURIZING=3, FAULT=4.
  - Shared by future airlock blocks and benches.
- Sub-module airlock_settle_cnt:
  - Parametrised by SETTLE_CYCLES.
  - Inputs: clear, sample. Output: accepted.
  - Instantiated once and fed the sensor selected by the current state.

## Test plan
- Reset with SETTLE_CYCLES=4 → InnerUnlock=1, all other outputs 0; begin_Evacuation with doors closed → Evacuation=1 next cycle; Evacuated held high 4 cycles → OuterUnlock=1, Evacuation=0.
- Evacuated pattern 1,1,0,1,1,1,1 → EVACUATED only after the final 4-high run.
- InnerClosed=0 during EVACUATING → Fault=1 next cycle, Evacuation=0; begin_Pressurize with doors closed → Pressurization=1; then Pressurized held 4 cycles → InnerUnlock=1.
- begin_Evacuation with OuterClosed=0 in PRESSURIZED → one Reject pulse, state unchanged.
- AIRLOCK_TIMEOUT_EN, TIMEOUT_CYCLES=16, Evacuated stuck at 0 → Fault=1 after 16 cycles in EVACUATING. Sensor accepted on the same edge as the timeout → EVACUATED, not FAULT.
- Reset=0 asserted mid-PRESSURIZING → next cycle PRESSURIZED, Pressurization=0.
